// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and parity helper.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Expected parity bit for a data word; zero-extension does not change it.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic [1:0] mode);
    case (mode)
      PARITY_EVEN: return ^data;
      PARITY_ODD:  return ~^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high serial line; resets to 1.
module uart_sync2 (
  input  logic clk_en_i,
  input  logic resetn_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_en_i or negedge resetn_i) begin
    if (!resetn_i) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with parity/framing status and a one-entry output buffer.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote on every line sample.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk_en_i,
  input  logic                 resetn_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] dataout_o,
  output logic                 dataout_valid_o,
  input  logic                 dataout_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int PH_W        = $clog2(OVERSAMPLE);
  localparam int BC_W        = $clog2(DATA_BITS + 1);
  localparam int SYNC_STAGES = 1;
  localparam bit HAS_PAR     = (PARITY_MODE != 0);

  localparam logic [PH_W-1:0] PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_END   = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_DLAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] BC_SLAST = BC_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_core: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be 4..64");
  end

  logic rx_s;
  logic smp;

  uart_sync2 u_sync (
    .clk_en_i (clk_en_i),
    .resetn_i (resetn_i),
    .d        (uart_rx_i),
    .q        (rx_s)
  );

  // The synchroniser comes out of reset holding 1s; arming waits until those
  // have flushed so a line held low through reset is never seen as high.
  logic [SYNC_STAGES:0] vld_pipe;
  logic                 sync_ok;

  always_ff @(posedge clk_en_i or negedge resetn_i) begin
    if (!resetn_i) vld_pipe <= '0;
    else           vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
  end

  assign sync_ok = vld_pipe[SYNC_STAGES];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk_en_i or negedge resetn_i) begin
    if (!resetn_i) rx_hist <= 2'b11;
    else           rx_hist <= {rx_hist[0], rx_s};
  end

  assign smp = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
  assign smp = rx_s;
`endif

  rx_state_t            state, state_nxt;
  logic [PH_W-1:0]      phase, phase_nxt;
  logic [BC_W-1:0]      bitcnt, bitcnt_nxt;
  logic                 armed, armed_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 commit_q, commit_nxt;

  always_ff @(posedge clk_en_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state    <= IDLE;
      phase    <= '0;
      bitcnt   <= '0;
      armed    <= 1'b0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bitcnt   <= bitcnt_nxt;
      armed    <= armed_nxt;
      shift    <= shift_nxt;
      perr     <= perr_nxt;
      ferr     <= ferr_nxt;
      commit_q <= commit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bitcnt_nxt = bitcnt;
    armed_nxt  = armed;
    shift_nxt  = shift;
    perr_nxt   = perr;
    ferr_nxt   = ferr;
    commit_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s && sync_ok) begin
          armed_nxt = 1'b1;
        end else if (armed && !rx_s) begin
          state_nxt = START;
          phase_nxt = '0;
        end
      end
      START: begin
        if (phase == PH_MID) begin
          phase_nxt = '0;
          if (smp) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = DATA;
            bitcnt_nxt = '0;
            perr_nxt   = 1'b0;
            ferr_nxt   = 1'b0;
          end
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      DATA: begin
        if (phase == PH_END) begin
          phase_nxt = '0;
          for (int i = 0; i < DATA_BITS; i++)
            if (bitcnt == BC_W'(i)) shift_nxt[i] = smp;
          if (bitcnt == BC_DLAST) begin
            bitcnt_nxt = '0;
            state_nxt  = HAS_PAR ? PARITY : STOP;
          end else begin
            bitcnt_nxt = bitcnt + BC_W'(1);
          end
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      PARITY: begin
        if (phase == PH_END) begin
          phase_nxt = '0;
          perr_nxt  = smp != parity_calc(MAX_DATA_BITS'(shift), 2'(PARITY_MODE));
          state_nxt = STOP;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      STOP: begin
        if (phase == PH_END) begin
          phase_nxt = '0;
          ferr_nxt  = ferr | ~smp;
          if (bitcnt == BC_SLAST) begin
            // Back to IDLE at once so the next start edge is caught mid stop bit.
            bitcnt_nxt = '0;
            state_nxt  = IDLE;
            armed_nxt  = 1'b0;
            commit_nxt = 1'b1;
          end else begin
            bitcnt_nxt = bitcnt + BC_W'(1);
          end
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_en_i or negedge resetn_i) begin
    if (!resetn_i) begin
      dataout_o       <= '0;
      dataout_valid_o <= 1'b0;
      parity_err_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (commit_q) begin
        if (!dataout_valid_o || dataout_ready_i) begin
          dataout_o       <= shift;
          parity_err_o    <= HAS_PAR & perr;
          frame_err_o     <= ferr;
          dataout_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (dataout_ready_i) begin
        dataout_valid_o <= 1'b0;
      end
    end
  end

endmodule
